// File: rtl/axi_rdata_gen_pkg.sv
// axi_rdata_gen_pkg: shared AXI burst/resp codes, AR request type and beat address helpers
package axi_rdata_gen_pkg;
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR = 2'd1;
  localparam logic [1:0] BURST_WRAP = 2'd2;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_RD, S_DATA} state_t;
  typedef struct packed {
    logic [39:0] addr;
    logic [1:0] burst;
    logic [7:0] id;
    logic [7:0] len;
    logic [2:0] size;
  } ar_req_t;
  function automatic logic req_err(input ar_req_t r, input int data_bytes);
    return r.burst == 2'b11 || int'(32'd1 << r.size) > data_bytes ||
      (r.burst == BURST_WRAP && !(r.len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction
  // First INCR/WRAP beat may be unaligned; later beats step from the aligned address
  function automatic logic [39:0] next_addr(input logic [39:0] a, input logic [1:0] burst,
                                            input logic [7:0] len, input logic [2:0] size);
    logic [39:0] step, nx, wsz, base;
    step = 40'd1 << size;
    nx = (a & ~(step - 40'd1)) + step;
    wsz = (40'(len) + 40'd1) << size;
    base = a & ~(wsz - 40'd1);
    return burst == BURST_WRAP && nx == base + wsz ? base :
      burst == BURST_INCR || burst == BURST_WRAP ? nx : a;
  endfunction
endpackage

// File: rtl/axi_rdata_req_fifo.sv
// axi_rdata_req_fifo: pointer-based AR request queue with full/empty flags
module axi_rdata_req_fifo import axi_rdata_gen_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic    cpu_clk,
  input  logic    cpu_rst,
  input  logic    push,
  input  logic    pop,
  input  ar_req_t wdata,
  output ar_req_t rdata,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);
  ar_req_t mem [DEPTH];
  logic [AW:0] wp, rp;
  assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign empty = wp == rp;
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge cpu_clk)
    if (push) mem[wp[AW-1:0]] <= wdata;
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + {{AW{1'b0}}, 1'b1};
      if (pop) rp <= rp + {{AW{1'b0}}, 1'b1};
    end
  end
endmodule

// File: rtl/axi_rdata_gen.sv
// axi_rdata_gen: queues AR requests and replays each as len+1 R beats read from a memory model
module axi_rdata_gen import axi_rdata_gen_pkg::*; #(
  parameter int AR_DEPTH = 4,
  parameter int DATA_W = 128
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              fifo_pad_arvalid,
  output logic              pad_biu_arready,
  input  logic [39:0]       fifo_pad_araddr,
  input  logic [1:0]        fifo_pad_arburst,
  input  logic [7:0]        fifo_pad_arid,
  input  logic [7:0]        fifo_pad_arlen,
  input  logic [2:0]        fifo_pad_arsize,
  output logic              pad_biu_rvalid,
  output logic [DATA_W-1:0] pad_biu_rdata,
  output logic [7:0]        pad_biu_rid,
  output logic [1:0]        pad_biu_rresp,
  output logic              pad_biu_rlast,
  input  logic              biu_pad_rready,
  output logic              mem_rd_en,
  output logic [39:0]       mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data
);
  state_t state;
  ar_req_t head, ctx;
  logic full, empty, err;
  logic [7:0] beat_cnt;
  assign pad_biu_arready = !full;
  assign mem_rd_en = state == S_RD && !err;
  assign mem_rd_addr = {ctx.addr[39:4], 4'b0};
  axi_rdata_req_fifo #(.DEPTH(AR_DEPTH)) u_fifo (
    .cpu_clk(cpu_clk),
    .cpu_rst(cpu_rst),
    .push(fifo_pad_arvalid && !full),
    .pop(state == S_IDLE && !empty),
    .wdata({fifo_pad_araddr, fifo_pad_arburst, fifo_pad_arid, fifo_pad_arlen, fifo_pad_arsize}),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state <= S_IDLE;
      ctx <= '0;
      err <= 1'b0;
      beat_cnt <= '0;
      pad_biu_rvalid <= 1'b0;
      pad_biu_rdata <= '0;
      pad_biu_rid <= '0;
      pad_biu_rresp <= RESP_OKAY;
      pad_biu_rlast <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (!empty) begin
          state <= S_RD;
          ctx <= head;
          err <= req_err(head, DATA_W / 8);
          beat_cnt <= '0;
        end
        S_RD: begin
          state <= S_DATA;
          pad_biu_rvalid <= 1'b1;
          pad_biu_rdata <= err ? '0 : mem_rd_data;
          pad_biu_rresp <= err ? RESP_SLVERR : RESP_OKAY;
          pad_biu_rid <= ctx.id;
          pad_biu_rlast <= beat_cnt == ctx.len;
        end
        S_DATA: if (biu_pad_rready) begin
          state <= pad_biu_rlast ? S_IDLE : S_RD;
          pad_biu_rvalid <= 1'b0;
          beat_cnt <= beat_cnt + 8'd1;
          ctx.addr <= next_addr(ctx.addr, ctx.burst, ctx.len, ctx.size);
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_rdata_gen.sv
// tb_axi_rdata_gen: scoreboard bench, expected beats and memory reads come from an arithmetic burst model
module tb_axi_rdata_gen;
  localparam int DW = 128;
  typedef struct {
    logic [7:0] id;
    logic [1:0] resp;
    logic last;
    logic [DW-1:0] data;
    bit first;
  } beat_t;
  logic clk = 0, rst = 1;
  logic arvalid = 0, arready;
  logic [39:0] araddr = '0;
  logic [1:0] arburst = '0;
  logic [7:0] arid = '0, arlen = '0;
  logic [2:0] arsize = '0;
  logic rvalid, rlast, rready = 0;
  logic [DW-1:0] rdata, mem_rd_data;
  logic [7:0] rid;
  logic [1:0] rresp;
  logic mem_rd_en;
  logic [39:0] mem_rd_addr;
  int checks = 0, failures = 0, cyc = 0, prev_hs = 0, beats_seen = 0;
  bit tput_on = 0, stall = 0;
  logic [138:0] held;
  beat_t sb[$];
  logic [39:0] mq[$];
  beat_t e;
  int wl[4] = '{1, 3, 7, 15};

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_val(input logic [39:0] a);
    return {4{a[31:0] ^ 32'h5A5A_0000}};
  endfunction
  assign mem_rd_data = mem_val(mem_rd_addr);

  axi_rdata_gen #(.AR_DEPTH(4), .DATA_W(DW)) dut (
    .cpu_clk(clk), .cpu_rst(rst),
    .fifo_pad_arvalid(arvalid), .pad_biu_arready(arready),
    .fifo_pad_araddr(araddr), .fifo_pad_arburst(arburst), .fifo_pad_arid(arid),
    .fifo_pad_arlen(arlen), .fifo_pad_arsize(arsize),
    .pad_biu_rvalid(rvalid), .pad_biu_rdata(rdata), .pad_biu_rid(rid),
    .pad_biu_rresp(rresp), .pad_biu_rlast(rlast), .biu_pad_rready(rready),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Burst rules computed with plain division: beat address, memory row, SLVERR handling
  function automatic void model(input logic [39:0] addr, input logic [1:0] burst, input logic [7:0] id,
                                input logic [7:0] len, input logic [2:0] size);
    longint unsigned a, bytes, nx, wsz, base, row;
    bit err;
    a = 64'(addr);
    bytes = 64'd1 << size;
    err = burst == 2'd3 || bytes > DW / 8 || (burst == 2'd2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    for (int i = 0; i <= int'(len); i++) begin
      row = (a / 16) * 16;
      if (!err) mq.push_back(row[39:0]);
      sb.push_back('{id, err ? 2'b10 : 2'b00, i == int'(len), err ? {DW{1'b0}} : mem_val(row[39:0]), i == 0});
      nx = (a / bytes) * bytes + bytes;
      if (burst == 2'd2) begin
        wsz = (64'(len) + 1) * bytes;
        base = (a / wsz) * wsz;
        if (nx >= base + wsz) nx = base;
      end
      if (burst != 2'd0) a = nx % (64'd1 << 40);
    end
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) stall = 0;
    else begin
      if (mem_rd_en) begin
        chk("mem_rd_expected", 160'(mq.size() != 0), 160'(1));
        if (mq.size() != 0) chk("mem_rd_addr", 160'(mem_rd_addr), 160'(mq.pop_front()));
      end
      if (stall) chk("r_stable", 160'({rvalid, rid, rresp, rlast, rdata}), 160'({1'b1, held}));
      stall = 0;
      if (rvalid && !rready) begin
        stall = 1;
        held = {rid, rresp, rlast, rdata};
      end
      if (rvalid && rready) begin
        chk("r_expected", 160'(sb.size() != 0), 160'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("r_beat", 160'({rid, rresp, rlast, rdata}), 160'({e.id, e.resp, e.last, e.data}));
          if (tput_on && !e.first) chk("r_gap", 160'(cyc - prev_hs), 160'(2));
        end
        prev_hs = cyc;
        beats_seen++;
      end
    end
  end

  task automatic send_ar(input logic [39:0] a, input logic [1:0] bu, input logic [7:0] id,
                         input logic [7:0] len, input logic [2:0] sz);
    int w = 0;
    @(posedge clk);
    #1;
    araddr = a;
    arburst = bu;
    arid = id;
    arlen = len;
    arsize = sz;
    arvalid = 1;
    do begin
      @(negedge clk);
      w++;
    end while (!arready && w < 200);
    chk("ar_accept", 160'(arready), 160'(1));
    if (arready) model(a, bu, id, len, sz);
    @(posedge clk);
    #1 arvalid = 0;
  endtask

  task automatic wait_drain();
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while ((sb.size() != 0 || mq.size() != 0 || rvalid) && w < 500);
    chk("drain", 160'(sb.size() + mq.size()), 160'(0));
  endtask

  initial begin
    int lat, b, w, seen, n;
    bit acc;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_rvalid", 160'(rvalid), 160'(0));
    chk("rst_arready", 160'(arready), 160'(1));
    chk("rst_mem_rd_en", 160'(mem_rd_en), 160'(0));
    chk("rst_r_payload", 160'({rid, rresp, rlast, rdata}), 160'(0));
    rready = 1;
    tput_on = 1;
    send_ar(40'h100, 2'd1, 8'h05, 8'd0, 3'd4);
    lat = 1;
    while (lat < 10) begin
      @(negedge clk);
      if (rvalid) break;
      @(posedge clk);
      lat++;
    end
    chk("latency", 160'(lat), 160'(3));
    wait_drain();
    send_ar(40'h208, 2'd1, 8'h11, 8'd3, 3'd4);
    wait_drain();
    send_ar(40'h1020, 2'd2, 8'h12, 8'd3, 3'd4);
    wait_drain();
    send_ar(40'hFF_FFFF_FFF0, 2'd1, 8'h13, 8'd1, 3'd4);
    wait_drain();
    send_ar(40'h345, 2'd0, 8'h14, 8'd2, 3'd2);
    wait_drain();
    tput_on = 0;
    rready = 0;
    for (int i = 0; i < 5; i++) send_ar(40'({$urandom(), $urandom()}), 2'd1, 8'(32'h20 + i), 8'd0, 3'd4);
    repeat (2) @(negedge clk);
    chk("full_arready", 160'(arready), 160'(0));
    chk("full_rvalid", 160'(rvalid), 160'(1));
    @(posedge clk);
    #1 rready = 1;
    wait_drain();
    send_ar(40'h400, 2'd3, 8'h31, 8'd1, 3'd2);
    send_ar(40'h500, 2'd2, 8'h32, 8'd2, 3'd4);
    send_ar(40'h600, 2'd1, 8'h33, 8'd0, 3'd5);
    wait_drain();
    b = beats_seen;
    send_ar(40'h800, 2'd1, 8'h40, 8'd7, 3'd4);
    w = 0;
    while (beats_seen < b + 2 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("two_beats", 160'(beats_seen >= b + 2), 160'(1));
    @(posedge clk);
    #1 rready = 0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!rvalid && w < 20);
    @(posedge clk);
    #1 rst = 1;
    sb.delete();
    mq.delete();
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("midrst_rvalid", 160'(rvalid), 160'(0));
    chk("midrst_arready", 160'(arready), 160'(1));
    rready = 1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rvalid) seen++;
    end
    chk("no_stale", 160'(seen), 160'(0));
    n = 0;
    w = 0;
    while ((n < 40 || sb.size() != 0 || mq.size() != 0 || arvalid) && w < 20000) begin
      @(negedge clk);
      w++;
      acc = arvalid && arready;
      if (acc) begin
        model(araddr, arburst, arid, arlen, arsize);
        n++;
      end
      @(posedge clk);
      #1;
      rready = $urandom_range(0, 3) != 0;
      if (acc) arvalid = 0;
      if (!arvalid && n < 40 && $urandom_range(0, 1) == 0) begin
        araddr = 40'({$urandom(), $urandom()});
        arburst = 2'($urandom_range(0, 3));
        arlen = 8'($urandom_range(0, 7));
        arsize = 3'($urandom_range(0, 5));
        if (arburst == 2'd2 && $urandom_range(0, 3) != 0) arlen = 8'(wl[$urandom_range(0, 3)]);
        arid = 8'($urandom());
        arvalid = 1;
      end
    end
    chk("rand_done", 160'(w < 20000), 160'(1));
    rready = 1;
    wait_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_rdata_gen.md
AXI_RDATA_GEN -- requirements
Module: axi_rdata_gen

Interface
REQ-001 SHALL declare parameter AR_DEPTH, default 4, read-request queue depth (power of 2, at least 2).
REQ-002 SHALL declare parameter DATA_W, default 128, R-channel data width in bits.
REQ-003 SHALL have port cpu_clk, input, 1, the single clock.
REQ-004 SHALL have port cpu_rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have ports fifo_pad_arvalid (input, 1) and pad_biu_arready (output, 1), the AR handshake with the upstream AR delay FIFO.
REQ-006 SHALL have inputs fifo_pad_araddr (40), fifo_pad_arburst (2), fifo_pad_arid (8), fifo_pad_arlen (8) and fifo_pad_arsize (3), which are the AR payload.
REQ-007 SHALL have outputs pad_biu_rvalid (1), pad_biu_rdata (DATA_W), pad_biu_rid (8), pad_biu_rresp (2) and pad_biu_rlast (1), and input biu_pad_rready (1), which form the R channel.
REQ-008 SHALL have outputs mem_rd_en (1) and mem_rd_addr (40), and input mem_rd_data (DATA_W), which form the memory model read port with 1-cycle read latency.

Function
REQ-009 SHALL accept an AR beat when fifo_pad_arvalid && pad_biu_arready.
- pad_biu_arready = !queue_full.
- Accepted {addr, burst, id, len, size} are pushed into an AR_DEPTH-entry FIFO.
REQ-010 SHALL pop the queue head in IDLE when the queue is non-empty.
- The head is loaded into the beat context: cur_addr, beat_cnt=0, id, len, size, burst, err.
REQ-011 SHALL set err when any of the following holds:
- arburst == 2'b11;
- (1<<arsize) exceeds DATA_W/8;
- burst is WRAP and arlen is not in {1, 3, 7, 15}.
REQ-012 SHALL implement the FSM IDLE -> RD -> DATA, with these transitions:
- RD -> DATA always;
- DATA -> RD on rready when the beat is not last;
- DATA -> IDLE on rready when the beat is last.
REQ-013 In RD, SHALL assert mem_rd_en for exactly one cycle with mem_rd_addr = {cur_addr[39:4], 4'b0}, except when err=1 (no memory access).
REQ-014 On entering DATA, SHALL register the beat:
- pad_biu_rdata = mem_rd_data, or 0 when err;
- pad_biu_rresp = 2'b00, or 2'b10 (SLVERR) when err;
- pad_biu_rid = id;
- pad_biu_rlast = (beat_cnt == len).
REQ-015 SHALL hold pad_biu_rvalid=1 and all R outputs stable in DATA until biu_pad_rready=1; rvalid SHALL NOT depend combinationally on rready.
REQ-016 SHALL advance the address after each accepted beat:
- FIXED: unchanged.
- INCR: aligned(cur_addr) + (1<<size), where the first beat may be unaligned.
- WRAP: same as INCR, except that the address returns to the wrap base (multiple of (len+1)<<size) on crossing the boundary.
REQ-017 SHALL have INCR wrap modulo 2^40 with no error.
REQ-018 SHALL emit exactly len+1 beats per request, including error bursts.
REQ-019 SHALL deliver R beats in AR acceptance order, with no interleaving.
REQ-020 SHALL allow a push while the FSM is busy.
- A push and a pop in the same cycle leave occupancy unchanged.
- A push when full is impossible, because arready=0.
REQ-021 SHALL give a latency from AR accept on an empty idle block to the first rvalid of 3 cycles (push, pop/IDLE, RD); throughput SHALL be 1 beat per 2 cycles.

Reset
REQ-022 When cpu_rst=1 at a cpu_clk edge, SHALL clear the queue, set the FSM to IDLE, and drive the following outputs:
- pad_biu_rvalid=0, mem_rd_en=0;
- pad_biu_rdata=0, rid=0, rresp=0, rlast=0;
- pad_biu_arready=1 starting from the first cycle after reset.
REQ-023 Reset mid-burst SHALL discard the remaining beats and all queued requests, with no further rvalid.

Structure
REQ-024 Burst codes (FIXED=0, INCR=1, WRAP=2) and resp codes (OKAY=0, SLVERR=2) SHALL reside in the shared axi package/include.
REQ-025 The AR queue SHALL be sub-module axi_rdata_req_fifo (pointer-based, full/empty flags, synchronous reset).

Verification
REQ-026 Single beat: AR addr=0x100, len=0, size=4, INCR, id=0x5 -> one beat with rid=0x5, rlast=1, rresp=0, mem_rd_addr=0x100, rvalid at cycle 3.
REQ-027 INCR: len=3, size=4, addr=0x208 -> mem_rd_addr sequence 0x200, 0x210, 0x220, 0x230; rlast only on the 4th beat.
REQ-028 WRAP: len=3, size=4, addr=0x1020 -> addresses 0x1020, 0x1030, 0x1000, 0x1010.
REQ-029 Backpressure/full: rready=0 and 5 ARs issued -> arready low after 4 are queued (1 held in context); rdata stable; beats drain in order once rready=1.
REQ-030 Errors: burst=3, len=1 -> 2 beats with rresp=2'b10, rdata=0, no mem_rd_en; WRAP with len=2 -> 3 SLVERR beats.
REQ-031 Reset mid-burst of len=7 after 2 beats -> rvalid=0 the next cycle, arready=1, and no stale beats afterwards.
